// File: rtl/noc_pkg.sv
// Shared mesh-router types: packet field positions, directions, FSM states
// and the dimension-ordered (XY) route function.
package noc_pkg;

  localparam int WIDTH_packet = 57;
  localparam int DST_X_MSB    = 56;
  localparam int DST_Y_MSB    = 52;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_S = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  // X is resolved first, then Y; a packet already at its target goes local.
  function automatic dir_e xy_route(input logic [3:0] dst_x, input logic [3:0] dst_y,
                                    input logic [3:0] my_x, input logic [3:0] my_y);
    dir_e r;
    if (dst_x > my_x)      r = DIR_E;
    else if (dst_x < my_x) r = DIR_W;
    else if (dst_y > my_y) r = DIR_S;
    else if (dst_y < my_y) r = DIR_N;
    else                   r = DIR_L;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from another timing domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/input_route_ctrl.sv
// Router input port: FIFO-buffers link packets, routes the head packet XY
// and hands it to one output gate over a four-phase req/ack handshake.
// Packets whose route points back where they came from are discarded.
module input_route_ctrl #(
  parameter int         WIDTH_packet = 57,
  parameter int         DEPTH        = 4,
  parameter logic [3:0] MY_X         = 4'd0,
  parameter logic [3:0] MY_Y         = 4'd0,
  parameter int         IN_DIR       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_packet-1:0] in_data,
  output logic [4:0]              out_req,
  input  logic [4:0]              out_ack,
  output logic [WIDTH_packet-1:0] out_data,
  output logic                    drop_pulse,
  output logic [15:0]             fwd_count,
  output logic                    busy
);

  import noc_pkg::*;

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]  IN_DIR_C = 3'(IN_DIR);

  // FIFO storage and bookkeeping
  logic [WIDTH_packet-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q;
  logic [WIDTH_packet-1:0] head_q;
  logic                    head_vld_q;
  logic                    full, empty, push, pop;

  // Handshake state
  state_e                  state_q, state_d;
  dir_e                    sel_q, sel_d;
  dir_e                    route;
  logic [WIDTH_packet-1:0] data_q, data_d;
  logic [15:0]             fwd_q, fwd_d;
  logic                    drop_q, drop_d;
  logic [4:0]              ack_s;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  sync_2ff #(.WIDTH(5)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (out_ack),
    .q_o   (ack_s)
  );

  // Storage array carries no reset so it maps onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Pointers, occupancy and the registered head read. The head is marked
  // invalid for the cycle after a pop so the FSM never acts on a stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      head_q     <= mem_q[rd_ptr_q];
      head_vld_q <= !empty && !pop;
    end
  end

  assign route = xy_route(head_q[DST_X_MSB -: 4], head_q[DST_Y_MSB -: 4], MY_X, MY_Y);

  // FSM state register plus the registered outputs it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= DIR_N;
      data_q  <= '0;
      fwd_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic; a new request waits until the gate's ack is seen low,
  // which also absorbs an ack left high across a reset.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    fwd_d   = fwd_q;
    drop_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_vld_q) begin
          if (route == IN_DIR_C) begin
            pop    = 1'b1;
            drop_d = 1'b1;
          end else if (!ack_s[route]) begin
            data_d  = head_q;
            sel_d   = route;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (ack_s[sel_q]) state_d = ST_REL;
      end
      ST_REL: begin
        if (!ack_s[sel_q]) begin
          pop     = 1'b1;
          fwd_d   = fwd_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: request is purely a function of state, so it falls the
  // moment reset is asserted.
  always_comb begin
    out_req = '0;
    if (state_q == ST_REQ) out_req[sel_q] = 1'b1;
  end

  assign out_data   = data_q;
  assign drop_pulse = drop_q;
  assign fwd_count  = fwd_q;
  assign busy       = !empty || (state_q != ST_IDLE);

endmodule
